// File: rtl/round_robin_dispatcher_with_2_targets_if.sv
// Handshake bundle for the two-target round-robin dispatcher: one upstream
// valid/ready stream in, two valid/ready streams out, plus the preferred-target hint.
interface round_robin_dispatcher_with_2_targets_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [WIDTH-1:0] out_data_0;
    logic [WIDTH-1:0] out_data_1;
    logic             next_target;

    // Dispatcher side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data_0, out_data_1, next_target
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data_0, out_data_1, next_target
    );
endinterface

// File: rtl/round_robin_dispatcher_with_2_targets.sv
// Round-robin split of one valid/ready stream across two per-target FIFOs.
// Optional macro RR_DISPATCH_SKIP_BUSY_EN: bypass a full preferred target instead of stalling.
module round_robin_dispatcher_with_2_targets #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    round_robin_dispatcher_with_2_targets_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]    wr_ptr_q [2];
    logic [AW-1:0]    wr_ptr_d [2];
    logic [AW-1:0]    rd_ptr_q [2];
    logic [AW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    count_q  [2];
    logic [CW-1:0]    count_d  [2];
    logic             next_target_q;
    logic             next_target_d;

    logic [1:0] full;
    logic [1:0] nonempty;
    logic [1:0] push;
    logic [1:0] pop;
    logic       chosen;
    logic       in_ready;
    logic       accept;

    // Full comes from registered counts only, so a same-cycle pop never frees a slot for a push.
    assign full     = {count_q[1] == FULL_CNT, count_q[0] == FULL_CNT};
    assign nonempty = {count_q[1] != '0, count_q[0] != '0};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        chosen = next_target_q;
`ifdef RR_DISPATCH_SKIP_BUSY_EN
        if (full[next_target_q]) chosen = ~next_target_q;
        in_ready = ~(full[0] & full[1]);
`else
        in_ready = ~full[next_target_q];
`endif
    end

    assign accept        = bus.in_valid & in_ready;
    assign push          = accept ? (chosen ? 2'b10 : 2'b01) : 2'b00;
    assign pop           = nonempty & bus.out_ready;
    assign next_target_d = accept ? ~chosen : next_target_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q      <= '{default: '0};
            rd_ptr_q      <= '{default: '0};
            count_q       <= '{default: '0};
            next_target_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            next_target_q <= next_target_d;
        end
    end

    // NOTE: FIFO storage is not reset; outputs are gated by occupancy so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push[0]) mem_q[0][wr_ptr_q[0]] <= bus.in_data;
        if (push[1]) mem_q[1][wr_ptr_q[1]] <= bus.in_data;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = nonempty;
    assign bus.out_data_0  = nonempty[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign bus.out_data_1  = nonempty[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    assign bus.next_target = next_target_q;
endmodule

// File: tb/tb_round_robin_dispatcher_with_2_targets.sv
// Bench for the two-target round-robin dispatcher: vector table, corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_round_robin_dispatcher_with_2_targets;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    round_robin_dispatcher_with_2_targets_if #(.WIDTH(WIDTH)) bus ();

    round_robin_dispatcher_with_2_targets #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one queue per target plus the preferred-target bit.
    logic [WIDTH-1:0] mq0 [$];
    logic [WIDTH-1:0] mq1 [$];
    logic             m_nt;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic [1:0]       r;
        logic             ir;
        logic             nt;
        logic [1:0]       ov;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [19:0] observe();
        return {bus.in_ready, bus.next_target, bus.out_valid, bus.out_data_0, bus.out_data_1};
    endfunction

    function automatic void model_reset();
        mq0.delete();
        mq1.delete();
        m_nt = 1'b0;
    endfunction

    // Drive one cycle, compare pre-edge outputs with the model, then advance model and DUT.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] r,
                        input string tag, output logic [19:0] obs);
        logic f0, f1, m_ir, m_ch, acc;
        logic [1:0] m_ov, pop;
        logic [WIDTH-1:0] h0, h1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        f0   = (mq0.size() == DEPTH);
        f1   = (mq1.size() == DEPTH);
        m_ov = {mq1.size() != 0, mq0.size() != 0};
        h0   = m_ov[0] ? mq0[0] : '0;
        h1   = m_ov[1] ? mq1[0] : '0;
`ifdef RR_DISPATCH_SKIP_BUSY_EN
        m_ir = !(f0 && f1);
        m_ch = (m_nt ? f1 : f0) ? ~m_nt : m_nt;
`else
        m_ir = m_nt ? !f1 : !f0;
        m_ch = m_nt;
`endif
        obs = observe();
        check(tag, 32'(obs), 32'({m_ir, m_nt, m_ov, h0, h1}));
        acc = v & m_ir;
        pop = m_ov & r;
        @(posedge clk);
        if (pop[0]) void'(mq0.pop_front());
        if (pop[1]) void'(mq1.pop_front());
        if (acc) begin
            if (m_ch) mq1.push_back(d);
            else      mq0.push_back(d);
            m_nt = ~m_ch;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [19:0] obs;

        // Test 1: four words alternate targets with both consumers ready.
        vecs[0]  = '{1'b1, 8'hA0, 2'b11, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 8'hA1, 2'b11, 1'b1, 1'b1, 2'b01, 8'hA0, 8'h00};
        vecs[2]  = '{1'b1, 8'hA2, 2'b11, 1'b1, 1'b0, 2'b10, 8'h00, 8'hA1};
        vecs[3]  = '{1'b1, 8'hA3, 2'b11, 1'b1, 1'b1, 2'b01, 8'hA2, 8'h00};
        vecs[4]  = '{1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 2'b10, 8'h00, 8'hA3};
        vecs[5]  = '{1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00};
        // Test 2: both consumers stalled, fifth word waits for a pop on target 0.
        vecs[6]  = '{1'b1, 8'h10, 2'b00, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 8'h11, 2'b00, 1'b1, 1'b1, 2'b01, 8'h10, 8'h00};
        vecs[8]  = '{1'b1, 8'h12, 2'b00, 1'b1, 1'b0, 2'b11, 8'h10, 8'h11};
        vecs[9]  = '{1'b1, 8'h13, 2'b00, 1'b1, 1'b1, 2'b11, 8'h10, 8'h11};
        vecs[10] = '{1'b1, 8'h14, 2'b00, 1'b0, 1'b0, 2'b11, 8'h10, 8'h11};
        vecs[11] = '{1'b1, 8'h14, 2'b01, 1'b0, 1'b0, 2'b11, 8'h10, 8'h11};
        vecs[12] = '{1'b1, 8'h14, 2'b00, 1'b1, 1'b0, 2'b11, 8'h12, 8'h11};
        vecs[13] = '{1'b0, 8'h00, 2'b11, 1'b0, 1'b1, 2'b11, 8'h12, 8'h11};
        vecs[14] = '{1'b0, 8'h00, 2'b11, 1'b1, 1'b1, 2'b11, 8'h14, 8'h13};
        vecs[15] = '{1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 2'b00;
        model_reset();
        #2;
        check("reset_state", 32'(observe()), 32'({1'b1, 1'b0, 2'b00, 8'h00, 8'h00}));
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r, $sformatf("model_vec%0d", i), obs);
            check($sformatf("vec%0d", i), 32'(obs),
                  32'({vecs[i].ir, vecs[i].nt, vecs[i].ov, vecs[i].d0, vecs[i].d1}));
        end

        // Test 3: target 1 full while target 0 drains continuously.
        do_reset();
        step(1'b1, 8'h30, 2'b01, "t1fill0", obs);
        step(1'b1, 8'h31, 2'b01, "t1fill1", obs);
        step(1'b1, 8'h32, 2'b01, "t1fill2", obs);
        step(1'b1, 8'h33, 2'b01, "t1fill3", obs);
        check("t1_full_ov", 32'(bus.out_valid[1]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'(8'h20 + k), 2'b01, $sformatf("skip%0d", k), obs);
`ifdef RR_DISPATCH_SKIP_BUSY_EN
            check($sformatf("skip_ready%0d", k), 32'(obs[19]), 32'd1);
`else
            check($sformatf("strict_ready%0d", k), 32'(obs[19]), 32'(!obs[18]));
`endif
        end

        // Test 4: full target 0 popped while a push aims at it; push is refused.
        do_reset();
        step(1'b1, 8'h40, 2'b00, "pp0", obs);
        step(1'b1, 8'h41, 2'b00, "pp1", obs);
        step(1'b1, 8'h42, 2'b00, "pp2", obs);
        step(1'b1, 8'h43, 2'b00, "pp3", obs);
        step(1'b1, 8'h44, 2'b01, "pp_same_cycle", obs);
        check("pp_refused", 32'(obs[19]), 32'd0);
        #1;
        check("pp_after", 32'({bus.out_valid, bus.out_data_0}), 32'({2'b11, 8'h42}));

        // Test 5: asynchronous reset between edges with three words buffered.
        bus.in_valid  = 1'b0;
        bus.out_ready = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 32'(observe()), 32'({1'b1, 1'b0, 2'b00, 8'h00, 8'h00}));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 8'h00, 2'b11, "post_reset_idle", obs);
        step(1'b1, 8'h50, 2'b00, "post_reset_push", obs);
        #1;
        check("post_reset_t0", 32'({bus.out_valid, bus.out_data_0}), 32'({2'b01, 8'h50}));

        // Test 6: wrap-around, 3*DEPTH words per target with both consumers ready.
        do_reset();
        for (int k = 0; k < 6 * DEPTH; k++)
            step(1'b1, 8'(8'h60 + k), 2'b11, $sformatf("wrap%0d", k), obs);
        step(1'b0, 8'h00, 2'b11, "wrap_drain0", obs);
        step(1'b0, 8'h00, 2'b11, "wrap_drain1", obs);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
                 $sformatf("rand%0d", k), obs);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
